mmu_arbiter: RTL and testbench

MMU_ARBITER -- requirements
Module: mmu_arbiter

---
 rtl/mmu_pkg.sv | 25 ++
 rtl/arb_pick.sv | 43 ++++
 rtl/mmu_arbiter.sv | 148 ++++++++++++++
 tb/tb_mmu_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types for the MMU line-request arbiter: FSM state encoding,
// request kind and the round-robin pointer wrap helper.
package mmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic {
    MMU_REQ_READ  = 1'b0,
    MMU_REQ_WRITE = 1'b1
  } mmu_req_e;

  // Port index following idx, wrapping back to 0 after n-1.
  function automatic int next_ptr(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: first eligible port at or after i_base,
// searching upward and wrapping modulo NPORTS.
module arb_pick
  import mmu_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] i_elig,
  input  logic [IW-1:0]     i_base,
  output logic [IW-1:0]     o_idx,
  output logic              o_valid
);

  logic          w_found;
  logic [IW-1:0] w_cand;
  int            w_pos;

  // Scan from the base pointer and keep the first hit.
  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    w_pos   = 0;
    for (int k = 0; k < NPORTS; k++) begin
      w_pos = int'(i_base) + k;
      if (w_pos >= NPORTS) begin
        w_pos = w_pos - NPORTS;
      end else begin
        w_pos = w_pos;
      end
      w_cand = IW'(w_pos);
      if (!w_found && i_elig[w_cand]) begin
        w_found = 1'b1;
        o_idx   = w_cand;
      end else begin
        w_found = w_found;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/mmu_arbiter.sv
// Arbitrates NPORTS L1 line requests onto a single MMU port (IDLE/BUSY/RELEASE).
// Define MMU_ARBITER_RR_EN for round-robin priority; otherwise lowest index wins.
module mmu_arbiter
  import mmu_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  localparam int IW    = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        req_read,
  input  logic [NPORTS-1:0]        req_write,
  input  logic [NPORTS*ADDR_W-1:0] req_addr,
  input  logic [NPORTS*LINE_W-1:0] req_wdata,
  output logic [NPORTS-1:0]        port_done,
  output logic [LINE_W-1:0]        port_rdata,
  output logic                     mmu_read,
  output logic                     mmu_write,
  output logic [ADDR_W-1:0]        mmu_addr,
  output logic [LINE_W-1:0]        mmu_wdata,
  input  logic                     mmu_done,
  input  logic [LINE_W-1:0]        mmu_rdata,
  output logic [IW-1:0]            grant_id,
  output logic                     busy
);

  arb_state_e          r_state;
  logic [IW-1:0]       r_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic                r_mmu_read;
  logic                r_mmu_write;
  logic                r_busy;

  logic [NPORTS-1:0]   w_elig;
  logic [IW-1:0]       w_base;
  logic [IW-1:0]       w_idx;
  logic                w_valid;
  mmu_req_e            w_kind;
  logic                w_finish;
  logic [NPORTS-1:0]   w_done;

  assign w_elig = req_read | req_write;

`ifdef MMU_ARBITER_RR_EN
  logic [IW-1:0] r_base;

  // Pointer to the port with top priority; reset favours port 0.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_base <= '0;
    end else if (r_state == ST_IDLE && w_valid) begin
      r_base <= IW'(next_ptr(int'(w_idx), NPORTS));
    end else begin
      r_base <= r_base;
    end
  end

  assign w_base = r_base;
`else
  assign w_base = '0;
`endif

  arb_pick #(
    .NPORTS (NPORTS),
    .IW     (IW)
  ) u_pick (
    .i_elig  (w_elig),
    .i_base  (w_base),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // A port raising both read and write is treated as a write.
  assign w_kind   = req_write[w_idx] ? MMU_REQ_WRITE : MMU_REQ_READ;
  assign w_finish = (r_state == ST_BUSY) && mmu_done;

  // Control FSM; latches the winner's request on the grant edge.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mmu_read  <= 1'b0;
      r_mmu_write <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state     <= ST_BUSY;
            r_grant     <= w_idx;
            r_addr      <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
            r_wdata     <= req_wdata[int'(w_idx)*LINE_W +: LINE_W];
            r_mmu_read  <= (w_kind == MMU_REQ_READ);
            r_mmu_write <= (w_kind == MMU_REQ_WRITE);
            r_busy      <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mmu_done) begin
            r_state     <= ST_RELEASE;
            r_mmu_read  <= 1'b0;
            r_mmu_write <= 1'b0;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        // One dead cycle so a requester's still-high level is not re-granted.
        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mmu_read  <= 1'b0;
          r_mmu_write <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Completion is forwarded in the same cycle the MMU reports it.
  always_comb begin
    w_done = '0;
    if (w_finish) begin
      w_done[r_grant] = 1'b1;
    end else begin
      w_done = '0;
    end
  end

  assign port_done  = w_done;
  assign port_rdata = w_finish ? mmu_rdata : '0;
  assign mmu_read   = r_mmu_read;
  assign mmu_write  = r_mmu_write;
  assign mmu_addr   = r_addr;
  assign mmu_wdata  = r_wdata;
  assign grant_id   = r_grant;
  assign busy       = r_busy;

endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed bench for mmu_arbiter: a 2-port instance for the main scenarios
// and a 4-port instance for the read+write collision case.
module tb_mmu_arbiter;

  logic sys_clk = 1'b0;
  logic rst_n;
  always #5 sys_clk = ~sys_clk;

  logic [1:0]   rd2, wr2, done2;
  logic [63:0]  addr2;
  logic [511:0] wdata2;
  logic [255:0] rdata2, mwdata2, mrdata2;
  logic [31:0]  maddr2;
  logic         mr2, mw2, mdone2, busy2;
  logic [0:0]   gid2;

  logic [3:0]    rd4, wr4, done4;
  logic [127:0]  addr4;
  logic [1023:0] wdata4;
  logic [255:0]  rdata4, mwdata4, mrdata4;
  logic [31:0]   maddr4;
  logic          mr4, mw4, mdone4, busy4;
  logic [1:0]    gid4;

  int n_vec = 0;
  int n_err = 0;

  mmu_arbiter #(.NPORTS(2), .ADDR_W(32), .LINE_W(256)) u_dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .req_read(rd2), .req_write(wr2), .req_addr(addr2), .req_wdata(wdata2),
    .port_done(done2), .port_rdata(rdata2),
    .mmu_read(mr2), .mmu_write(mw2), .mmu_addr(maddr2), .mmu_wdata(mwdata2),
    .mmu_done(mdone2), .mmu_rdata(mrdata2), .grant_id(gid2), .busy(busy2)
  );

  mmu_arbiter #(.NPORTS(4), .ADDR_W(32), .LINE_W(256)) u_dut4 (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .req_read(rd4), .req_write(wr4), .req_addr(addr4), .req_wdata(wdata4),
    .port_done(done4), .port_rdata(rdata4),
    .mmu_read(mr4), .mmu_write(mw4), .mmu_addr(maddr4), .mmu_wdata(mwdata4),
    .mmu_done(mdone4), .mmu_rdata(mrdata4), .grant_id(gid4), .busy(busy4)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [255:0] w1;
  logic [255:0] a5;
  int exp_g [4];

  initial begin
    w1 = {8{32'hDEADBEEF}};
    a5 = {32{8'hA5}};
`ifdef MMU_ARBITER_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    rst_n = 1'b0;
    rd2 = '0; wr2 = '0; addr2 = '0; wdata2 = '0; mdone2 = 1'b0; mrdata2 = '0;
    rd4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0; mdone4 = 1'b0; mrdata4 = '0;
    tick(); tick();
    chk("rst_busy", busy2, 0);
    chk("rst_mr", mr2, 0);
    chk("rst_mw", mw2, 0);
    chk("rst_addr", maddr2, 0);
    chk("rst_gid", gid2, 0);
    chk("rst_done", done2, 0);
    chk("rst_rdata", rdata2, 0);
    rst_n = 1'b1;
    tick();

    // Single read from port 1, done three cycles after the grant.
    rd2 = 2'b10; addr2[63:32] = 32'h0000_1000;
    tick();
    chk("rd_mr0", mr2, 1);
    chk("rd_mw0", mw2, 0);
    chk("rd_addr", maddr2, 32'h1000);
    chk("rd_gid", gid2, 1);
    chk("rd_busy", busy2, 1);
    chk("rd_nodone", done2, 0);
    tick();
    chk("rd_mr1", mr2, 1);
    tick();
    mdone2 = 1'b1; mrdata2 = a5;
    #1;
    chk("rd_mr2", mr2, 1);
    chk("rd_done", done2, 2'b10);
    chk("rd_rdata", rdata2, a5);
    tick();
    mdone2 = 1'b0; rd2 = 2'b00;
    #1;
    chk("rel_mr", mr2, 0);
    chk("rel_busy", busy2, 1);
    chk("rel_done", done2, 0);
    chk("rel_rdata", rdata2, 0);
    tick();
    chk("idle_busy", busy2, 0);
    chk("idle_addr_hold", maddr2, 32'h1000);

    // A done pulse while idle must be ignored.
    mdone2 = 1'b1;
    #1;
    chk("idle_done_ign", done2, 0);
    tick();
    mdone2 = 1'b0;
    chk("idle_stay", busy2, 0);

    // Contention between ports 0 and 1, both held high.
    rd2 = 2'b11; addr2 = {32'h0000_0200, 32'h0000_0100};
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("cont_gid%0d", g), gid2, exp_g[g]);
      chk($sformatf("cont_addr%0d", g), maddr2, (exp_g[g] == 0) ? 32'h100 : 32'h200);
      mdone2 = 1'b1;
      #1;
      chk($sformatf("cont_done%0d", g), done2, (exp_g[g] == 0) ? 2'b01 : 2'b10);
      tick();
      mdone2 = 1'b0;
      #1;
      chk($sformatf("cont_rel_mr%0d", g), mr2, 0);
      tick();
      chk($sformatf("cont_idle%0d", g), busy2, 0);
    end
    rd2 = 2'b00;
    tick();
    chk("withdraw_busy", busy2, 0);

    // Port inputs changing mid-BUSY must not reach the MMU outputs.
    wr2 = 2'b01; addr2 = {32'h0, 32'h0000_0020}; wdata2 = {256'h0, w1};
    tick();
    chk("wr_mw", mw2, 1);
    chk("wr_mr", mr2, 0);
    chk("wr_gid", gid2, 0);
    chk("wr_addr", maddr2, 32'h20);
    chk("wr_wdata", mwdata2, w1);
    addr2[31:0] = 32'h0000_0040; wdata2[255:0] = ~w1;
    tick();
    chk("wr_addr_hold", maddr2, 32'h20);
    chk("wr_wdata_hold", mwdata2, w1);
    mdone2 = 1'b1;
    tick();
    mdone2 = 1'b0; wr2 = 2'b00;
    #1;
    chk("wr_rel_mw", mw2, 0);
    chk("wr_rel_addr", maddr2, 32'h20);
    tick();

    // Stale request held through RELEASE and the first IDLE cycle edge.
    rd2 = 2'b01; addr2[31:0] = 32'h0000_0300;
    tick();
    chk("st_mr", mr2, 1);
    mdone2 = 1'b1;
    tick();
    mdone2 = 1'b0;
    #1;
    chk("st_rel_mr", mr2, 0);
    chk("st_rel_busy", busy2, 1);
    tick();
    chk("st_nogrant_mr", mr2, 0);
    chk("st_nogrant_busy", busy2, 0);
    rd2 = 2'b00;
    tick();
    chk("st_dropped", busy2, 0);

    // Reset while port 1 is granted.
    rd2 = 2'b10; addr2[63:32] = 32'h0000_0500; wdata2[511:256] = w1;
    tick();
    chk("rb_gid", gid2, 1);
    chk("rb_mr", mr2, 1);
    rst_n = 1'b0; rd2 = 2'b00;
    tick();
    chk("rb_mr0", mr2, 0);
    chk("rb_mw0", mw2, 0);
    chk("rb_addr0", maddr2, 0);
    chk("rb_wdata0", mwdata2, 0);
    chk("rb_gid0", gid2, 0);
    chk("rb_busy0", busy2, 0);
    rst_n = 1'b1;
    mdone2 = 1'b1; mrdata2 = a5;
    #1;
    chk("rb_done_ign", done2, 0);
    chk("rb_rdata0", rdata2, 0);
    tick();
    mdone2 = 1'b0;
    chk("rb_idle", busy2, 0);

    // Four ports: port 3 raises read and write together.
    rd4 = 4'b1000; wr4 = 4'b1000; addr4[127:96] = 32'h0000_0ABC;
    tick();
    chk("rw_mw", mw4, 1);
    chk("rw_mr", mr4, 0);
    chk("rw_gid", gid4, 3);
    chk("rw_addr", maddr4, 32'hABC);
    mdone4 = 1'b1;
    #1;
    chk("rw_done", done4, 4'b1000);
    tick();
    mdone4 = 1'b0; rd4 = '0; wr4 = '0;
    #1;
    chk("rw_rel_mw", mw4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
